lpm_fifo_sc: RTL

Single-clock synchronous FIFO in the LPM synthesizable-model family. It buffers words produced by registered stages such as flip-flop banks and counters and hands them to a downstream consumer under a request/flag handshake. Flags and word count are exact and registered. It supports normal (read-latency 1) and show-ahead read modes.

---
 rtl/lpm_fifo_sc.sv | 87 ++++++++
 1 files changed

// File: rtl/lpm_fifo_sc.sv
// lpm_fifo_sc: single-clock FIFO with exact registered flags, normal or show-ahead read
// Ports: clock, aclr (async clear), sclr (sync clear), data/wrreq (write side),
//        q/rdreq (read side), full, empty, usedw (count mod 2^lpm_widthu).
// Build macro LPM_FIFO_ALMOST_FLAGS_EN adds almost_full/almost_empty and their thresholds.
module lpm_fifo_sc #(
  parameter int    lpm_width     = 8,
  parameter int    lpm_widthu    = 4,
  parameter int    lpm_numwords  = 16,
  parameter string lpm_showahead = "OFF"
`ifdef LPM_FIFO_ALMOST_FLAGS_EN
  ,
  parameter int    lpm_almostfull  = 12,
  parameter int    lpm_almostempty = 4
`endif
) (
  input  logic                  clock,
  input  logic                  aclr,
  input  logic                  sclr,
  input  logic [lpm_width-1:0]  data,
  input  logic                  wrreq,
  input  logic                  rdreq,
  output logic [lpm_width-1:0]  q,
  output logic                  full,
  output logic                  empty,
  output logic [lpm_widthu-1:0] usedw
`ifdef LPM_FIFO_ALMOST_FLAGS_EN
  ,
  output logic                  almost_full,
  output logic                  almost_empty
`endif
);
  localparam int CW = lpm_widthu + 1;
  localparam logic [lpm_widthu-1:0] last = lpm_widthu'(lpm_numwords - 1);
  logic [lpm_width-1:0] mem [lpm_numwords];
  logic [lpm_widthu-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic wr_en, rd_en;
  always_comb begin
    wr_en = wrreq && !full;
    rd_en = rdreq && !empty;
    wr_ptr_nxt = sclr ? '0 : !wr_en ? wr_ptr : wr_ptr == last ? '0 : wr_ptr + 1'b1;
    rd_ptr_nxt = sclr ? '0 : !rd_en ? rd_ptr : rd_ptr == last ? '0 : rd_ptr + 1'b1;
    cnt_nxt = sclr ? '0 : (wr_en && !rd_en) ? cnt + 1'b1 : (rd_en && !wr_en) ? cnt - 1'b1 : cnt;
  end
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      cnt    <= cnt_nxt;
      full   <= cnt_nxt == CW'(lpm_numwords);
      empty  <= cnt_nxt == '0;
    end
  end
  // storage is never cleared; a clear at the same edge cancels the write
  always_ff @(posedge clock)
    if (wr_en && !sclr && !aclr) mem[wr_ptr] <= data;
  // truncation gives the documented wrap to 0 when full at a power-of-two depth
  assign usedw = cnt[lpm_widthu-1:0];
  generate
    if (lpm_showahead == "ON") begin : g_show
      // forced to 0 while empty so a clear also shows q = 0
      assign q = empty ? '0 : mem[rd_ptr];
    end else begin : g_norm
      always_ff @(posedge clock or posedge aclr) begin
        if (aclr) q <= '0;
        else q <= sclr ? '0 : rd_en ? mem[rd_ptr] : q;
      end
    end
  endgenerate
`ifdef LPM_FIFO_ALMOST_FLAGS_EN
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      almost_full  <= 1'b0;
      almost_empty <= lpm_almostempty > 0;
    end else begin
      almost_full  <= int'(cnt_nxt) >= lpm_almostfull;
      almost_empty <= int'(cnt_nxt) < lpm_almostempty;
    end
  end
`endif
endmodule
